fifo_single_clock_multimode: RTL and testbench



---
 rtl/fifo_single_clock_multimode.sv | 107 ++++++++++
 tb/tb_fifo_single_clock_multimode.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_single_clock_multimode.sv
// Single-clock FIFO with selectable FWFT or registered read, occupancy count,
// almost thresholds, synchronous flush and saturating over/underflow counters.
module fifo_single_clock_multimode #(
   parameter int unsigned DATA_WIDTH          = 8,
   parameter int unsigned LOG2_OF_DEPTH       = 4,
   parameter bit          FWFT                = 1'b1,
   parameter int unsigned ALMOST_FULL_MARGIN  = 2,
   parameter int unsigned ALMOST_EMPTY_MARGIN = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [DATA_WIDTH-1:0]    data_in,
   input  logic                     write_enable,
   input  logic                     read_enable,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic                     data_out_valid,
   output logic [LOG2_OF_DEPTH:0]   count,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [31:0]              write_error_count,
   output logic [31:0]              read_error_count
);

   localparam int unsigned DEPTH = 1 << LOG2_OF_DEPTH;
   localparam int unsigned AW    = LOG2_OF_DEPTH;
   localparam int unsigned CW    = LOG2_OF_DEPTH + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         read_address;
   logic [AW-1:0]         write_address;
   logic                  read_accept;
   logic                  write_accept;

   // Status flags are decoded straight from the occupancy register.
   always_comb begin
      full         = (count == CW'(DEPTH));
      empty        = (count == '0);
      almost_full  = (count >= CW'(DEPTH - ALMOST_FULL_MARGIN));
      almost_empty = (count <= CW'(ALMOST_EMPTY_MARGIN));
   end

   // A write into a full FIFO is allowed only when a read frees a slot the same cycle.
   always_comb begin
      read_accept  = read_enable && !empty;
      write_accept = write_enable && (!full || read_accept);
   end

   always_ff @(posedge clock) begin
      if (!reset && !flush && write_accept) begin
         mem[write_address] <= data_in;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         read_address  <= '0;
         write_address <= '0;
         count         <= '0;
      end else begin
         if (write_accept) write_address <= write_address + AW'(1);
         if (read_accept)  read_address  <= read_address + AW'(1);
         case ({write_accept, read_accept})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Error counters survive flush and stick at all-ones.
   always_ff @(posedge clock) begin
      if (reset) begin
         write_error_count <= '0;
         read_error_count  <= '0;
      end else if (!flush) begin
         if (write_enable && !write_accept && (write_error_count != '1))
            write_error_count <= write_error_count + 32'd1;
         if (read_enable && !read_accept && (read_error_count != '1))
            read_error_count <= read_error_count + 32'd1;
      end
   end

   generate
      if (FWFT) begin : g_fwft
         assign data_out       = mem[read_address];
         assign data_out_valid = !empty;
      end else begin : g_registered
         always_ff @(posedge clock) begin
            if (reset) begin
               data_out       <= '0;
               data_out_valid <= 1'b0;
            end else if (flush) begin
               data_out_valid <= 1'b0;
            end else if (read_accept) begin
               data_out       <= mem[read_address];
               data_out_valid <= 1'b1;
            end else begin
               data_out_valid <= 1'b0;
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_fifo_single_clock_multimode.sv
// Bench: FWFT and registered-read instances on shared stimulus, checked against a queue model.
module tb_fifo_single_clock_multimode;

   localparam int unsigned DEPTH = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       flush = 1'b0;
   logic       write_enable = 1'b0;
   logic       read_enable = 1'b0;
   logic [7:0] data_in = 8'd0;

   logic [7:0]  dout1, dout0;
   logic        dv1, dv0;
   logic [4:0]  c1, c0;
   logic        f1, e1, af1, ae1, f0, e0, af0, ae0;
   logic [31:0] werr1, rerr1, werr0, rerr0;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   fifo_single_clock_multimode #(.DATA_WIDTH(8), .LOG2_OF_DEPTH(4), .FWFT(1'b1),
      .ALMOST_FULL_MARGIN(2), .ALMOST_EMPTY_MARGIN(2)) dut_fwft (
      .clock(clock), .reset(reset), .flush(flush), .data_in(data_in),
      .write_enable(write_enable), .read_enable(read_enable),
      .data_out(dout1), .data_out_valid(dv1), .count(c1), .full(f1), .empty(e1),
      .almost_full(af1), .almost_empty(ae1),
      .write_error_count(werr1), .read_error_count(rerr1));

   fifo_single_clock_multimode #(.DATA_WIDTH(8), .LOG2_OF_DEPTH(4), .FWFT(1'b0),
      .ALMOST_FULL_MARGIN(2), .ALMOST_EMPTY_MARGIN(2)) dut_reg (
      .clock(clock), .reset(reset), .flush(flush), .data_in(data_in),
      .write_enable(write_enable), .read_enable(read_enable),
      .data_out(dout0), .data_out_valid(dv0), .count(c0), .full(f0), .empty(e0),
      .almost_full(af0), .almost_empty(ae0),
      .write_error_count(werr0), .read_error_count(rerr0));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of words plus error tallies and the registered-read output.
   logic [7:0]  q[$];
   logic [31:0] m_werr, m_rerr;
   logic [7:0]  m_dout;
   logic        m_dv;
   bit          started = 1'b0;

   always @(posedge clock) begin
      bit ra, wa;
      if (reset) begin
         q.delete();
         m_werr  = 32'd0;
         m_rerr  = 32'd0;
         m_dout  = 8'd0;
         m_dv    = 1'b0;
         started = 1'b1;
      end else if (flush) begin
         q.delete();
         m_dv = 1'b0;
      end else begin
         ra = read_enable && (q.size() > 0);
         wa = write_enable && ((q.size() < DEPTH) || ra);
         if (read_enable && !ra && m_rerr != 32'hFFFF_FFFF) m_rerr = m_rerr + 32'd1;
         if (write_enable && !wa && m_werr != 32'hFFFF_FFFF) m_werr = m_werr + 32'd1;
         if (ra) begin
            m_dout = q.pop_front();
            m_dv   = 1'b1;
         end else begin
            m_dv = 1'b0;
         end
         if (wa) q.push_back(data_in);
      end
   end

   always @(negedge clock) begin
      int sz;
      if (started) begin
         sz = q.size();
         check("count_fwft", 32'(c1), 32'(sz));
         check("count_reg",  32'(c0), 32'(sz));
         check("full",  32'({f1, f0}),  {30'd0, {2{sz == DEPTH}}});
         check("empty", 32'({e1, e0}),  {30'd0, {2{sz == 0}}});
         check("almost_full",  32'({af1, af0}), {30'd0, {2{sz >= 14}}});
         check("almost_empty", 32'({ae1, ae0}), {30'd0, {2{sz <= 2}}});
         check("werr_fwft", werr1, m_werr);
         check("rerr_fwft", rerr1, m_rerr);
         check("werr_reg",  werr0, m_werr);
         check("rerr_reg",  rerr0, m_rerr);
         check("valid_fwft", 32'(dv1), 32'(sz != 0));
         if (sz != 0) check("data_fwft", 32'(dout1), 32'(q[0]));
         check("valid_reg", 32'(dv0), 32'(m_dv));
         check("data_reg",  32'(dout0), 32'(m_dout));
      end
   end

   // Drive one cycle of inputs, then return 2 ns after the edge that samples them.
   task automatic cyc(input logic we, input logic re, input logic [7:0] d,
                      input logic fl = 1'b0, input logic rs = 1'b0);
      write_enable = we;
      read_enable  = re;
      data_in      = d;
      flush        = fl;
      reset        = rs;
      @(posedge clock);
      #2;
   endtask

   initial begin
      logic [7:0] e;
      #1;
      cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
      check("rst_count", 32'(c1), 32'd0);
      check("rst_empty", 32'(e1), 32'd1);
      check("rst_full", 32'(f1), 32'd0);
      check("rst_ae", 32'(ae1), 32'd1);
      check("rst_af", 32'(af1), 32'd0);
      check("rst_dout_reg", 32'(dout0), 32'd0);
      check("rst_dv_reg", 32'(dv0), 32'd0);
      check("rst_werr", werr0, 32'd0);

      // Fill to full, then overflow once
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 1'b0, 8'(i));
         check("fill_count", 32'(c1), 32'(i + 1));
         check("fill_af", 32'(af1), 32'((i + 1) >= 14));
      end
      check("fill_full", 32'(f1), 32'd1);
      check("fill_werr", werr1, 32'd0);
      cyc(1'b1, 1'b0, 8'd16);
      check("ovf_werr", werr1, 32'd1);
      check("ovf_count", 32'(c1), 32'd16);

      // Full with simultaneous write and read
      check("full_head_fwft", 32'(dout1), 32'd0);
      cyc(1'b1, 1'b1, 8'd17);
      check("full_rw_count", 32'(c1), 32'd16);
      check("full_rw_dout", 32'(dout0), 32'd0);
      check("full_rw_dv", 32'(dv0), 32'd1);
      check("full_rw_werr", werr1, 32'd1);
      check("full_rw_rerr", rerr1, 32'd0);

      // Drain: 1..15 then 17
      for (int k = 0; k < 16; k++) begin
         e = (k < 15) ? 8'(k + 1) : 8'd17;
         check("drain_head_fwft", 32'(dout1), 32'(e));
         cyc(1'b0, 1'b1, 8'd0);
         check("drain_dout", 32'(dout0), 32'(e));
         check("drain_ae", 32'(ae1), 32'((15 - k) <= 2));
      end
      check("drain_empty", 32'(e1), 32'd1);

      // Underflow, then empty with read+write
      cyc(1'b0, 1'b1, 8'd0);
      check("unf_rerr", rerr1, 32'd1);
      check("unf_count", 32'(c1), 32'd0);
      cyc(1'b1, 1'b1, 8'd18);
      check("emp_rw_rerr", rerr1, 32'd2);
      check("emp_rw_count", 32'(c1), 32'd1);
      cyc(1'b0, 1'b1, 8'd0);
      check("emp_rw_read", 32'(dout0), 32'd18);

      // Read latency of both modes
      cyc(1'b1, 1'b0, 8'hA5);
      check("a5_fwft", 32'(dout1), 32'hA5);
      check("a5_fwft_v", 32'(dv1), 32'd1);
      check("a5_reg_v_pre", 32'(dv0), 32'd0);
      cyc(1'b0, 1'b1, 8'd0);
      check("a5_reg", 32'(dout0), 32'hA5);
      check("a5_reg_v", 32'(dv0), 32'd1);
      cyc(1'b0, 1'b0, 8'd0);
      check("a5_reg_v_drop", 32'(dv0), 32'd0);
      check("a5_reg_hold", 32'(dout0), 32'hA5);

      // Wrap: prefill 3, then 40 simultaneous write/read cycles
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(100 + i));
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, 1'b1, 8'(103 + i));
         check("wrap_dout", 32'(dout0), 32'(100 + i));
         check("wrap_count", 32'(c1), 32'd3);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b1, 8'd0);
         check("wrap_tail", 32'(dout0), 32'(140 + i));
      end

      // Flush at count 7 with write and read requested
      for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'(i));
      check("pre_flush_count", 32'(c1), 32'd7);
      cyc(1'b1, 1'b1, 8'h55, 1'b1);
      check("flush_count", 32'(c1), 32'd0);
      check("flush_empty", 32'(e1), 32'd1);
      check("flush_werr", werr1, 32'd1);
      check("flush_rerr", rerr1, 32'd2);
      check("flush_dv", 32'(dv0), 32'd0);
      cyc(1'b0, 1'b0, 8'd0);
      check("post_flush_count", 32'(c1), 32'd0);

      // Reset mid-stream
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(i + 60));
      cyc(1'b1, 1'b0, 8'd9, 1'b0, 1'b1);
      check("mrst_count", 32'(c1), 32'd0);
      check("mrst_empty", 32'(e1), 32'd1);
      check("mrst_ae", 32'(ae1), 32'd1);
      check("mrst_dout", 32'(dout0), 32'd0);
      check("mrst_werr", werr1, 32'd0);
      check("mrst_rerr", rerr0, 32'd0);
      cyc(1'b0, 1'b0, 8'd0);
      cyc(1'b0, 1'b0, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
